alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares one combinational `alu` instance between `NUM_REQ` requesters, for example the execute stage, the branch-compare unit and the address generator.
- Each requester issues an operation with a valid/ready handshake. The arbiter drives the winner's operands onto the shared ALU and captures the result in a registered response slot.
- The response is returned to the winner with a valid/ready handshake that supports back-pressure.
- The block sits between the issue logic and the ALU and owns all of the ALU's inputs.

## Interface
- `NUM_REQ`, default 2, number of requesters; legal range 2..4.
- `IDW`, default `$clog2(NUM_REQ)`, width of the requester index.

- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_req_valid`  in  `[NUM_REQ]`  requester k has an operation pending.
- `o_req_ready`  out  `[NUM_REQ]`  one-hot or zero; operation k is accepted this cycle.
- `i_req_operand_a`  in  `[NUM_REQ][32]`  operand a for each requester.
- `i_req_operand_b`  in  `[NUM_REQ][32]`  operand b for each requester.
- `i_req_alu_op`  in  `ALUSel_e [NUM_REQ]`  operation for each requester.
- `i_req_lock`  in  `[NUM_REQ]`  hold the grant for the next operation (see Configuration).
- `o_alu_operand_a`, `o_alu_operand_b`  out  32 each  drive the shared ALU.
- `o_alu_op`  out  `ALUSel_e`  drives the shared ALU.
- `i_alu_res`  in  32  combinational result from the shared ALU.
- `o_rsp_valid`  out  `[NUM_REQ]`  one-hot or zero; the response slot holds a result for requester k.
- `i_rsp_ready`  in  `[NUM_REQ]`  requester k consumes its response.
- `o_rsp_data`  out  32  registered result; shared by all requesters and qualified by `o_rsp_valid`.
- `o_rsp_id`  out  `IDW`  index of the owner of the response slot.

## Operation
- State machine states:
  - `IDLE`: response slot empty.
  - `RESP`: slot full, `o_rsp_valid[owner]` = 1.
- Accept condition `acc` = (state == `IDLE`) OR (state == `RESP` AND `i_rsp_ready[owner]`).
  - When `acc` holds and any `i_req_valid` bit is set, grant g is chosen round-robin.
  - The search starts at `(last_grant + 1) mod NUM_REQ` and takes the first set bit.
- Behaviour in the grant cycle:
  - `o_req_ready[g]` = 1.
  - `o_alu_operand_a/b` and `o_alu_op` = requester g's inputs.
  - At the clock edge: `o_rsp_data` ← `i_alu_res`, `o_rsp_id` ← g, `last_grant` ← g, state → `RESP`.
- No grant in a cycle:
  - ALU inputs are driven to 0 and `ALU_ADD`.
  - All `o_req_ready` = 0.
- `RESP` exit rules:
  - `i_rsp_ready[owner]` with no new grant: state → `IDLE`; `o_rsp_data` holds its value.
  - `i_rsp_ready[owner]` with a new grant: stay in `RESP` with the new owner. Throughput is one operation per cycle.
  - `i_rsp_ready` bits of non-owners are ignored.
- Requesters must hold operands and op stable while valid and not ready. The arbiter does not check this.
- The result width is exactly 32 bits; ALU overflow and carry are not propagated.

## Timing
- Reset values:
  - state `IDLE`.
  - `o_rsp_valid` = 0, `o_rsp_data` = 0, `o_rsp_id` = 0.
  - `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
  - `lock_q` = 0.
- Latency: request accepted in cycle N gives `o_rsp_valid` in cycle N+1.
- Combinational paths:
  - `i_req_valid` → `o_req_ready`.
  - `i_req_*` → `o_alu_*`.
  - `i_rsp_ready` → `o_req_ready`.
  - There is no combinational path from `i_alu_res` to any output.
- Simultaneous requests: exactly one is granted per cycle. A continuously asserted request waits at most `NUM_REQ-1` grants.
- Reset asserted mid-operation:
  - Outputs go to their reset values immediately.
  - A held response is discarded and is not replayed.
  - No `o_req_ready` is asserted while `i_rst_n` = 0.

## Configuration
- Macro `ALU_ARB_LOCK_EN`, when defined:
  - If the granted requester has `i_req_lock[g]` = 1 at acceptance, `lock_q` ← 1 and `lock_id` ← g.
  - While `lock_q` = 1, only `lock_id` can be granted; other requesters see `o_req_ready` = 0.
  - `lock_q` clears when `lock_id` is accepted with `i_req_lock` = 0.
  - Round-robin resumes from `lock_id`.
- Macro not defined: the `i_req_lock` port exists but is ignored, and pure round-robin applies.

## Test plan
- Single requester: req0 `ALU_ADD` a = 5, b = 7 → `o_req_ready[0]` in the same cycle; next cycle `o_rsp_valid` = 01, `o_rsp_data` = 12, `o_rsp_id` = 0.
- Contention after reset: both valid; req0 `ALU_SUB` 10−3, req1 `ALU_SLL` 1<<4; `i_rsp_ready` held at 1 →
  - req0 is granted first and returns 7;
  - req1 is granted in the next cycle and returns 16;
  - grants alternate 0, 1, 0, 1 while both requests stay asserted.
- Back-pressure: req1 response held with `i_rsp_ready[1]` = 0 for 3 cycles while req0 is valid →
  - `o_req_ready[0]` stays 0;
  - `o_rsp_data` is stable;
  - req0 is accepted in the cycle `i_rsp_ready[1]` rises.
- Non-owner ready: `i_rsp_ready[0]` = 1 while req1 owns the slot → no state change.
- Reset mid-response: deassert `i_rst_n` while `o_rsp_valid` = 10 → `o_rsp_valid` = 0 and `o_rsp_data` = 0 immediately; after release, req0 wins the first contended grant.
- `ALU_ARB_LOCK_EN` defined: req1 is accepted with lock = 1, then issues two more with lock 1 then 0, while req0 is valid throughout → three consecutive req1 grants, then req0 is granted.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Shared-ALU arbiter port bundle, plus the ALU operation encoding it carries.
// The arbiter side uses the slave modport; requesters and the ALU use master.
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } ALUSel_e;
endpackage

interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);
  import alu_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [NUM_REQ-1:0][31:0] i_req_operand_a;
  logic [NUM_REQ-1:0][31:0] i_req_operand_b;
  ALUSel_e                  i_req_alu_op [NUM_REQ];
  logic [NUM_REQ-1:0]       i_req_lock;
  logic [31:0]              o_alu_operand_a;
  logic [31:0]              o_alu_operand_b;
  ALUSel_e                  o_alu_op;
  logic [31:0]              i_alu_res;
  logic [NUM_REQ-1:0]       o_rsp_valid;
  logic [NUM_REQ-1:0]       i_rsp_ready;
  logic [31:0]              o_rsp_data;
  logic [IDW-1:0]           o_rsp_id;

  modport slave (
    input  i_req_valid, i_req_operand_a, i_req_operand_b, i_req_alu_op, i_req_lock,
    input  i_alu_res, i_rsp_ready,
    output o_req_ready, o_alu_operand_a, o_alu_operand_b, o_alu_op,
    output o_rsp_valid, o_rsp_data, o_rsp_id
  );

  modport master (
    output i_req_valid, i_req_operand_a, i_req_operand_b, i_req_alu_op, i_req_lock,
    output i_alu_res, i_rsp_ready,
    input  o_req_ready, o_alu_operand_a, o_alu_operand_b, o_alu_op,
    input  o_rsp_valid, o_rsp_data, o_rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// with a single registered response slot. Define ALU_ARB_LOCK_EN to enable grant locking.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_arbiter_if.slave bus
);
  import alu_arbiter_pkg::*;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [31:0]        data_q, data_d;
  logic [NUM_REQ-1:0] eligible;
  logic               acc;
  logic               grant_vld;
  logic [IDW-1:0]     grant;

`ifdef ALU_ARB_LOCK_EN
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;

  always_comb begin
    eligible = bus.i_req_valid;
    if (lock_q) begin
      eligible = bus.i_req_valid & (NUM_REQ'(1) << lock_id_q);
    end
  end

  // Every acceptance re-evaluates the lock, which both sets and clears it.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (acc && grant_vld) begin
      lock_d    = bus.i_req_lock[grant];
      lock_id_d = grant;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_req_lock;
  assign eligible    = bus.i_req_valid;
`endif

  // Slot can take a new result when empty or when its owner drains it this cycle.
  assign acc = i_rst_n && ((state_q == StIdle) || bus.i_rsp_ready[owner_q]);

  always_comb begin
    logic [IDW-1:0] idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = last_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + IDW'(1);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    last_d              = last_q;
    data_d              = data_q;
    bus.o_req_ready     = '0;
    bus.o_alu_operand_a = '0;
    bus.o_alu_operand_b = '0;
    bus.o_alu_op        = ALU_ADD;
    if (acc && grant_vld) begin
      bus.o_req_ready[grant] = 1'b1;
      bus.o_alu_operand_a    = bus.i_req_operand_a[grant];
      bus.o_alu_operand_b    = bus.i_req_operand_b[grant];
      bus.o_alu_op           = bus.i_req_alu_op[grant];
      state_d                = StResp;
      owner_d                = grant;
      last_d                 = grant;
      data_d                 = bus.i_alu_res;
    end else if (state_q == StResp && bus.i_rsp_ready[owner_q]) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_rsp_valid = (state_q == StResp) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.o_rsp_data  = data_q;
  assign bus.o_rsp_id    = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (two requesters) with a response scoreboard.
// Lock expectations follow ALU_ARB_LOCK_EN.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned IDW     = 1;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input ALUSel_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  // Shared ALU outside the arbiter
  assign bus.i_alu_res = alu_model(bus.o_alu_op, bus.o_alu_operand_a, bus.o_alu_operand_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1 with inputs set; checks before the next edge, then advances.
  task automatic cycle(input logic [1:0] exp_ready);
    exp_t           e;
    logic [IDW-1:0] g;
    #3;
    chk("req_ready", 32'(bus.o_req_ready), 32'(exp_ready));
    if (sb.size() > 0) begin
      e = sb[0];
      chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(1) << e.id);
      chk("rsp_id", 32'(bus.o_rsp_id), 32'(e.id));
      chk("rsp_data", bus.o_rsp_data, e.data);
      if (bus.i_rsp_ready[e.id]) void'(sb.pop_front());
    end else begin
      chk("rsp_empty", 32'(bus.o_rsp_valid), 32'd0);
    end
    if (exp_ready != 2'b00) begin
      g = exp_ready[1];
      chk("alu_a", bus.o_alu_operand_a, bus.i_req_operand_a[g]);
      chk("alu_b", bus.o_alu_operand_b, bus.i_req_operand_b[g]);
      chk("alu_op", 32'(bus.o_alu_op), 32'(bus.i_req_alu_op[g]));
      e.id   = g;
      e.data = alu_model(bus.i_req_alu_op[g], bus.i_req_operand_a[g], bus.i_req_operand_b[g]);
      sb.push_back(e);
    end else begin
      chk("alu_idle_a", bus.o_alu_operand_a, 32'd0);
      chk("alu_idle_op", 32'(bus.o_alu_op), 32'(ALU_ADD));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.i_req_valid     = 2'b11;
    bus.i_req_lock      = 2'b00;
    bus.i_rsp_ready     = 2'b00;
    bus.i_req_operand_a = '0;
    bus.i_req_operand_b = '0;
    bus.i_req_alu_op[0] = ALU_ADD;
    bus.i_req_alu_op[1] = ALU_ADD;

    // Reset state, and no grant while held in reset
    #2;
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.o_rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(bus.o_rsp_id), 32'd0);
    chk("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    bus.i_req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester: 5 + 7
    bus.i_req_valid        = 2'b01;
    bus.i_req_operand_a[0] = 32'd5;
    bus.i_req_operand_b[0] = 32'd7;
    bus.i_req_alu_op[0]    = ALU_ADD;
    cycle(2'b01);
    chk("single_data", bus.o_rsp_data, 32'd12);
    chk("single_valid", 32'(bus.o_rsp_valid), 32'b01);
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b01;
    cycle(2'b00);
    cycle(2'b00);

    // Contention after reset: 0 first, then alternate
    apply_reset();
    bus.i_req_valid        = 2'b11;
    bus.i_rsp_ready        = 2'b11;
    bus.i_req_operand_a[0] = 32'd10;
    bus.i_req_operand_b[0] = 32'd3;
    bus.i_req_alu_op[0]    = ALU_SUB;
    bus.i_req_operand_a[1] = 32'd1;
    bus.i_req_operand_b[1] = 32'd4;
    bus.i_req_alu_op[1]    = ALU_SLL;
    cycle(2'b01);
    chk("cont_sub", bus.o_rsp_data, 32'd7);
    cycle(2'b10);
    chk("cont_sll", bus.o_rsp_data, 32'd16);
    cycle(2'b01);
    cycle(2'b10);
    bus.i_req_valid = 2'b00;
    cycle(2'b00);

    // Back-pressure on req1's response, including non-owner ready
    bus.i_req_valid = 2'b10;
    bus.i_rsp_ready = 2'b00;
    cycle(2'b10);
    bus.i_req_valid = 2'b01;
    cycle(2'b00);
    chk("bp_data0", bus.o_rsp_data, 32'd16);
    cycle(2'b00);
    chk("bp_data1", bus.o_rsp_data, 32'd16);
    bus.i_rsp_ready = 2'b01;
    cycle(2'b00);
    chk("nonowner_valid", 32'(bus.o_rsp_valid), 32'b10);
    chk("nonowner_data", bus.o_rsp_data, 32'd16);
    bus.i_rsp_ready = 2'b10;
    cycle(2'b01);
    chk("bp_release_data", bus.o_rsp_data, 32'd7);
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b11;
    cycle(2'b00);
    cycle(2'b00);

    // Reset while req1 holds the slot
    bus.i_req_valid = 2'b10;
    bus.i_rsp_ready = 2'b00;
    cycle(2'b10);
    chk("pre_rst_valid", 32'(bus.o_rsp_valid), 32'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_rst_data", bus.o_rsp_data, 32'd0);
    bus.i_req_valid = 2'b11;
    bus.i_rsp_ready = 2'b11;
    #1;
    chk("mid_rst_ready", 32'(bus.o_req_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(2'b01);
    cycle(2'b10);
    cycle(2'b01);

    // Lock: req1 locks, holds, releases while req0 stays valid
    bus.i_req_lock = 2'b10;
    cycle(2'b10);
    bus.i_req_lock = 2'b10;
`ifdef ALU_ARB_LOCK_EN
    cycle(2'b10);
    bus.i_req_lock = 2'b00;
    cycle(2'b10);
    cycle(2'b01);
`else
    cycle(2'b01);
    bus.i_req_lock = 2'b00;
    cycle(2'b10);
    cycle(2'b01);
`endif
    bus.i_req_valid = 2'b00;
    cycle(2'b00);
    cycle(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
